// File: rtl/regfile_init_seq_if.sv
// Load-stream handshake bundle for regfile_init_seq.
// master: loader drives valid/addr/data/last; slave: sequencer drives ready.
interface regfile_init_seq_if #(
  parameter int XLEN = 32
) ();
  logic            load_valid;
  logic            load_ready;
  logic [4:0]      load_addr;
  logic [XLEN-1:0] load_data;
  logic            load_last;

  modport master (
    output load_valid,
    output load_addr,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_addr,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/regfile_init_seq.sv
// Regfile write-side init sequencer: clear sweep x1..xN-1, then streamed preload.
// Ports: clk, rst (sync, active-high), start, ld (load stream, slave),
//   regwrite/rd/writedata (regfile write port), core_stall, busy, done, err_x0.
// Optional REGFILE_INIT_READBACK_EN: adds VERIFY state, rs1/readdata1, mismatch.
module regfile_init_seq #(
  parameter int              NUM_REGS    = 32,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  regfile_init_seq_if.slave ld,
  output logic              regwrite,
  output logic [4:0]        rd,
  output logic [XLEN-1:0]   writedata,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err_x0
`ifdef REGFILE_INIT_READBACK_EN
  ,
  output logic [4:0]        rs1,
  input  logic [XLEN-1:0]   readdata1,
  output logic              mismatch
`endif
);

  localparam int CW = 6;
  localparam logic [CW-1:0] LAST_REG = CW'(NUM_REGS - 1);

`ifdef REGFILE_INIT_READBACK_EN
  localparam logic [CW-1:0] VFY_END = CW'(NUM_REGS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_VERIFY,
    S_LOAD,
    S_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DONE
  } state_e;
`endif

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic            rdy_q;
  logic            rdy_d;
  logic            rw_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] wd_d;
  logic            busy_d;
  logic            done_d;
  logic            err_d;
  logic            hs;

`ifdef REGFILE_INIT_READBACK_EN
  logic [4:0]      rs1_d;
  logic            iss_q;
  logic            iss_d;
  logic            v1_q;
  logic            v2_q;
  logic            mm_d;
`endif

  assign ld.load_ready = rdy_q;
  assign hs = ld.load_valid && rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = CW'(1);
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_REG) begin
`ifdef REGFILE_INIT_READBACK_EN
          state_d = S_VERIFY;
          cnt_d   = CW'(1);
`else
          state_d = S_LOAD;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef REGFILE_INIT_READBACK_EN
      // Two extra cycles drain the rs1 -> readdata1 pipeline.
      S_VERIFY: begin
        if (cnt_q == VFY_END) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_LOAD: begin
        if (hs && ld.load_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    rw_d   = 1'b0;
    rd_d   = rd;
    wd_d   = writedata;
    rdy_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = err_x0;
`ifdef REGFILE_INIT_READBACK_EN
    rs1_d  = '0;
    iss_d  = 1'b0;
    mm_d   = mismatch;
    if (v2_q && (readdata1 != CLEAR_VALUE)) begin
      mm_d = 1'b1;
    end
`endif
    unique case (state_d)
      S_IDLE: begin
        rd_d = '0;
        wd_d = '0;
      end
      S_CLEAR: begin
        rw_d = 1'b1;
        rd_d = cnt_d[4:0];
        wd_d = CLEAR_VALUE;
      end
`ifdef REGFILE_INIT_READBACK_EN
      // rd parks on the top register so x0 forwarding cannot mask a read.
      S_VERIFY: begin
        rd_d = LAST_REG[4:0];
        if (cnt_d <= LAST_REG) begin
          rs1_d = cnt_d[4:0];
          iss_d = 1'b1;
        end
      end
`endif
      S_LOAD: begin
        rdy_d = 1'b1;
      end
      default: begin
      end
    endcase
    if (hs) begin
      if (ld.load_addr != 5'd0) begin
        rw_d = 1'b1;
        rd_d = ld.load_addr;
        wd_d = ld.load_data;
      end else begin
        err_d = 1'b1;
      end
    end
    if ((state_q == S_IDLE) && start) begin
      err_d = 1'b0;
`ifdef REGFILE_INIT_READBACK_EN
      mm_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite   <= 1'b0;
      rd         <= '0;
      writedata  <= '0;
      rdy_q      <= 1'b0;
      core_stall <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_x0     <= 1'b0;
    end else begin
      regwrite   <= rw_d;
      rd         <= rd_d;
      writedata  <= wd_d;
      rdy_q      <= rdy_d;
      core_stall <= busy_d;
      busy       <= busy_d;
      done       <= done_d;
      err_x0     <= err_d;
    end
  end

`ifdef REGFILE_INIT_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1      <= '0;
      iss_q    <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      rs1      <= rs1_d;
      iss_q    <= iss_d;
      v1_q     <= iss_q;
      v2_q     <= v1_q;
      mismatch <= mm_d;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_init_seq.sv
// Randomized bench for regfile_init_seq with a per-cycle expected-output model.
// A small regfile model tracks DUT writes; final contents checked after each run.
module tb_regfile_init_seq;
  localparam int N = 32;
`ifdef REGFILE_INIT_READBACK_EN
  localparam logic [31:0] CV = 32'hA5A5A5A5;
`else
  localparam logic [31:0] CV = 32'h0000_0000;
`endif

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  rs1;
    logic        mm;
  } exp_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [1:0]  gap;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic regwrite;
  logic [4:0] rd;
  logic [31:0] writedata;
  logic core_stall;
  logic busy;
  logic done;
  logic err_x0;
  logic force7;
`ifdef REGFILE_INIT_READBACK_EN
  logic [4:0] rs1;
  logic [31:0] readdata1;
  logic [31:0] rd_p;
  logic mismatch;
`endif

  regfile_init_seq_if #(.XLEN(32)) ld ();

  always #5 clk = ~clk;

  regfile_init_seq #(
    .NUM_REGS   (N),
    .XLEN       (32),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ld        (ld),
    .regwrite  (regwrite),
    .rd        (rd),
    .writedata (writedata),
    .core_stall(core_stall),
    .busy      (busy),
    .done      (done),
    .err_x0    (err_x0)
`ifdef REGFILE_INIT_READBACK_EN
    ,
    .rs1       (rs1),
    .readdata1 (readdata1),
    .mismatch  (mismatch)
`endif
  );

  logic [31:0] rf [N];
  logic [31:0] mrf [N];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) rf[i] <= (i == 0) ? 32'h0 : (32'h1000_0000 | i);
    end else if (regwrite) begin
      rf[rd] <= writedata;
    end
  end

`ifdef REGFILE_INIT_READBACK_EN
  always @(posedge clk) begin
    rd_p      <= (force7 && rs1 == 5'd7) ? 32'h0 : rf[rs1];
    readdata1 <= rd_p;
  end
`endif

  exp_t e;
  bit   chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  string       lit_name [$];
  logic [31:0] lit_got [$];
  logic [31:0] lit_want [$];
  string       ln;
  logic [31:0] lg;
  logic [31:0] lw;

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (regwrite !== e.rw || rd !== e.rd || writedata !== e.wd ||
          ld.load_ready !== e.rdy || busy !== e.busy ||
          core_stall !== e.busy || done !== e.done || err_x0 !== e.err) begin
        miscompares++;
        $display("FAIL outs t=%0t got rw=%b rd=%0d wd=%h rdy=%b busy=%b stall=%b done=%b err=%b want rw=%b rd=%0d wd=%h rdy=%b busy=%b done=%b err=%b",
                 $time, regwrite, rd, writedata, ld.load_ready, busy,
                 core_stall, done, err_x0, e.rw, e.rd, e.wd, e.rdy,
                 e.busy, e.done, e.err);
      end
`ifdef REGFILE_INIT_READBACK_EN
      if (rs1 !== e.rs1 || mismatch !== e.mm) begin
        miscompares++;
        $display("FAIL rdback t=%0t got rs1=%0d mm=%b want rs1=%0d mm=%b",
                 $time, rs1, mismatch, e.rs1, e.mm);
      end
`endif
    end
    while (lit_name.size() > 0) begin
      ln = lit_name.pop_front();
      lg = lit_got.pop_front();
      lw = lit_want.pop_front();
      vectors++;
      if (lg !== lw) begin
        miscompares++;
        $display("FAIL %s got %h want %h", ln, lg, lw);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] w);
    lit_name.push_back(nm);
    lit_got.push_back(g);
    lit_want.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e.rw   = 1'b0;
    e.rd   = '0;
    e.wd   = '0;
    e.rdy  = 1'b0;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.rs1  = '0;
  endtask

  task automatic noise();
    ld.load_valid = 1'($urandom_range(0, 1));
    ld.load_addr  = 5'($urandom);
    ld.load_data  = $urandom;
    ld.load_last  = 1'($urandom_range(0, 1));
  endtask

  // Start a run; stop_at>0 asserts rst during that clear cycle.
  task automatic run_clear(input int stop_at);
    start = 1'b1;
    noise();
    for (int k = 1; k < N; k++) begin
      tick();
      if (k == 1) begin
        e.err = 1'b0;
        e.mm  = 1'b0;
      end
      e.rw   = 1'b1;
      e.rd   = 5'(k);
      e.wd   = CV;
      e.rdy  = 1'b0;
      e.busy = 1'b1;
      e.done = 1'b0;
      e.rs1  = '0;
      mrf[k] = CV;
      start  = 1'($urandom_range(0, 1));
      noise();
      if (k == stop_at) begin
        rst = 1'b1;
        tick();
        set_idle();
        e.err = 1'b0;
        e.mm  = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
    end
`ifdef REGFILE_INIT_READBACK_EN
    for (int v = 1; v <= N + 1; v++) begin
      tick();
      e.rw  = 1'b0;
      e.rd  = 5'(N - 1);
      e.rs1 = (v < N) ? 5'(v) : 5'd0;
      if (force7 && v >= 10) e.mm = 1'b1;
      start = 1'($urandom_range(0, 1));
      noise();
    end
`endif
  endtask

  ent_t ents [$];

  task automatic run_load();
    start = 1'b0;
    noise();
    tick();
    e.rw  = 1'b0;
    e.rdy = 1'b1;
    e.rs1 = '0;
    for (int i = 0; i < ents.size(); i++) begin
      for (int g = 0; g < int'(ents[i].gap); g++) begin
        noise();
        ld.load_valid = 1'b0;
        tick();
        e.rw = 1'b0;
      end
      ld.load_valid = 1'b1;
      ld.load_addr  = ents[i].a;
      ld.load_data  = ents[i].d;
      ld.load_last  = (i == ents.size() - 1);
      tick();
      if (ents[i].a != 5'd0) begin
        e.rw = 1'b1;
        e.rd = ents[i].a;
        e.wd = ents[i].d;
        mrf[ents[i].a] = ents[i].d;
      end else begin
        e.rw  = 1'b0;
        e.err = 1'b1;
      end
      if (i == ents.size() - 1) begin
        e.rdy  = 1'b0;
        e.done = 1'b1;
      end
    end
    start = 1'($urandom_range(0, 1));
    noise();
    tick();
    set_idle();
    start = 1'b0;
    noise();
    tick();
    for (int i = 0; i < N; i++) lit($sformatf("x%0d", i), rf[i], mrf[i]);
  endtask

  task automatic rand_ents();
    int n;
    ents = {};
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      ent_t t;
      t.a   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, N - 1));
      t.d   = $urandom;
      t.gap = 2'($urandom_range(0, 3));
      ents.push_back(t);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mrf[i] = '0;
    force7 = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_addr  = '0;
    ld.load_data  = '0;
    ld.load_last  = 1'b0;
    tick();
    e = '0;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    ents = {};
    ents.push_back('{a: 5'd9, d: 32'hDEADBEEF, gap: 2'd0});
    ents.push_back('{a: 5'd3, d: 32'h12345678, gap: 2'd0});
`ifdef REGFILE_INIT_READBACK_EN
    force7 = 1'b1;
`endif
    run_clear(0);
    force7 = 1'b0;
    run_load();
    lit("x9_lit", rf[9], 32'hDEADBEEF);
    lit("x3_lit", rf[3], 32'h12345678);
    lit("x1_lit", rf[1], CV);
`ifdef REGFILE_INIT_READBACK_EN
    lit("mm_set", 32'(mismatch), 32'd1);
`endif

    ents = {};
    ents.push_back('{a: 5'd0, d: 32'hFFFFFFFF, gap: 2'd0});
    ents.push_back('{a: 5'd12, d: 32'h0BAD_F00D, gap: 2'd1});
    run_clear(0);
    run_load();
    lit("err_lit", 32'(err_x0), 32'd1);
    lit("x0_lit", rf[0], 32'd0);
    lit("x12_lit", rf[12], 32'h0BAD_F00D);

    ents = {};
    ents.push_back('{a: 5'd5, d: 32'd1, gap: 2'd0});
    ents.push_back('{a: 5'd5, d: 32'd2, gap: 2'd1});
    run_clear(0);
    run_load();
    lit("x5_lit", rf[5], 32'd2);
    lit("err_clr", 32'(err_x0), 32'd0);
`ifdef REGFILE_INIT_READBACK_EN
    lit("mm_clr", 32'(mismatch), 32'd0);
`endif

    run_clear(10);
    noise();
    tick();
    lit("busy_rst", 32'(busy), 32'd0);
    rand_ents();
    run_clear(0);
    run_load();

    repeat (20) begin
      rand_ents();
      run_clear(0);
      run_load();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
